// File: rtl/token_pkg.sv
// Shared types and default constants for the token pacer block.
package token_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    SPACE = 2'd2
  } token_pacer_state_t;

  localparam int TOKEN_CAPACITY_DEF = 200;
  localparam int TOKEN_GAP_DEF      = 1;

endpackage

// File: rtl/token_gap_timer.sv
// Loadable down-counter that times the idle gap after each accepted token.
// A load sets the count so that done is high on the last gap cycle; with
// GAP == 0 there is no gap, so the timer collapses to a constant done.
module token_gap_timer #(
  parameter int GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  generate
    if (GAP == 0) begin : g_off
      assign done = 1'b1;
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst_n, load};
    end else begin : g_on
      localparam int TW = $clog2(GAP + 1);
      logic [TW-1:0] count_q;
      logic [TW-1:0] count_d;

      // Next count: reload on handshake, otherwise run down to zero and hold.
      always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (load) begin
          count_d = TW'(GAP - 1);
        end else if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
      end

      // Count register.
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignment so all flops update together at the edge.
        if (!rst_n) begin
          count_q <= '0;
        end else begin
          count_q <= count_d;
        end
      end

      assign done = (count_q == '0);
    end
  endgenerate

endmodule

// File: rtl/token_pacer.sv
// Token pacer: collects single-cycle token pulses into a bounded pending
// count and releases them one at a time on a valid/ready output, with GAP
// idle cycles after each accepted token. Overflow is sticky once a token is
// refused because the store is full.
// Optional build macro TOKEN_PACER_STATS_EN adds a saturating 16-bit
// drop_cnt output counting refused tokens.
module token_pacer
  import token_pkg::*;
#(
  parameter int CAPACITY = TOKEN_CAPACITY_DEF,
  parameter int GAP      = TOKEN_GAP_DEF,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow
`ifdef TOKEN_PACER_STATS_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam bit HAS_GAP = (GAP > 0);

  token_pacer_state_t state_q, state_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               overflow_q, overflow_d;

  logic hs;
  logic full;
  logic accept;
  logic drop;
  logic gap_done;

  assign out_valid = (state_q == OFFER);
  assign hs        = out_valid & out_ready;
  // A handshake in the same cycle frees a slot, so a full store still takes the token.
  assign full      = (pending_q == CNT_W'(CAPACITY));
  assign accept    = a & ~(full & ~hs);
  // Tokens arriving during clr are ignored, not dropped.
  assign drop      = a & ~accept & ~clr;

  token_gap_timer #(
    .GAP (GAP)
  ) u_gap_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hs),
    .done  (gap_done)
  );

  // Pending count and sticky overflow update.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q | drop;
    if (clr) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (accept && !hs) begin
      pending_d = pending_q + 1'b1;
    end else if (!accept && hs) begin
      pending_d = pending_q - 1'b1;
    end
  end

  // Next-state logic for the offer / gap sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pending_d != '0) state_d = OFFER;
      end
      OFFER: begin
        if (hs) begin
          if (HAS_GAP)               state_d = SPACE;
          else if (pending_d != '0)  state_d = OFFER;
          else                       state_d = IDLE;
        end
      end
      SPACE: begin
        if (gap_done) state_d = (pending_d != '0) ? OFFER : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // State, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pending  = pending_q;
  assign overflow = overflow_q;

`ifdef TOKEN_PACER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of refused tokens.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_token_pacer.sv
// Self-checking bench for token_pacer: one instance with CAPACITY=4/GAP=2,
// one with CAPACITY=4/GAP=0. A token-count model tracks each instance and is
// compared every cycle; directed scenarios add hand-computed expectations.
module tb_token_pacer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] a_i;
  logic [1:0] clr_i;
  logic [1:0] rdy_i;
  logic [1:0] valid_o;
  logic [2:0] pend_o [2];
  logic [1:0] ovf_o;
  logic [15:0] drop_o [2];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  checking = 1'b0;

  always #5 clk = ~clk;

  token_pacer #(.CAPACITY(4), .GAP(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_i[0]),
    .clr       (clr_i[0]),
    .out_valid (valid_o[0]),
    .out_ready (rdy_i[0]),
    .pending   (pend_o[0]),
    .overflow  (ovf_o[0])
`ifdef TOKEN_PACER_STATS_EN
    ,
    .drop_cnt  (drop_o[0])
`endif
  );

  token_pacer #(.CAPACITY(4), .GAP(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a_i[1]),
    .clr       (clr_i[1]),
    .out_valid (valid_o[1]),
    .out_ready (rdy_i[1]),
    .pending   (pend_o[1]),
    .overflow  (ovf_o[1])
`ifdef TOKEN_PACER_STATS_EN
    ,
    .drop_cnt  (drop_o[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tokens held, sticky flag, drop count, and the earliest cycle the
  // next offer may appear (set GAP+1 cycles after each accepted token).
  int m_pend     [2];
  int m_ready_at [2];
  int m_drop     [2];
  bit m_ovf      [2];
  int m_gap      [2];
  int cyc;

  function automatic bit m_valid(input int k);
    return (m_pend[k] > 0) && (cyc >= m_ready_at[k]);
  endfunction

  initial begin
    m_gap[0] = 2;
    m_gap[1] = 0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_ready_at[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
    end
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_pend[k] = 0; m_ready_at[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
        end
        cyc = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          bit hs;
          bit acc;
          if (clr_i[k]) begin
            m_pend[k] = 0; m_ready_at[k] = 0; m_drop[k] = 0; m_ovf[k] = 1'b0;
          end else begin
            hs  = m_valid(k) && rdy_i[k];
            acc = a_i[k] && !((m_pend[k] == 4) && !hs);
            if (a_i[k] && !acc) begin
              m_ovf[k] = 1'b1;
              if (m_drop[k] < 65535) m_drop[k]++;
            end
            m_pend[k] = m_pend[k] + (acc ? 1 : 0) - (hs ? 1 : 0);
            if (hs) m_ready_at[k] = cyc + 1 + m_gap[k];
          end
        end
        cyc++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("model_valid[%0d]", k), 32'(valid_o[k]), 32'(m_valid(k)));
          check($sformatf("model_pending[%0d]", k), 32'(pend_o[k]), m_pend[k]);
          check($sformatf("model_overflow[%0d]", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
`ifdef TOKEN_PACER_STATS_EN
          check($sformatf("model_drop[%0d]", k), 32'(drop_o[k]), m_drop[k]);
`endif
        end
      end
    end
  end

  task automatic cyc_end();
    @(posedge clk);
    #2;
  endtask

  logic [8:0] vbits;
  logic [3:0] vb0;

  initial begin
    a_i = '0; clr_i = '0; rdy_i = '0;
    #1 rst_n = 1'b0;
    checking = 1'b1;
    #1;
    check("reset_valid", 32'(valid_o[0]), 0);
    check("reset_pending", 32'(pend_o[0]), 0);
    check("reset_overflow", 32'(ovf_o[0]), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc_end(); cyc_end();

    // Single token.
    a_i[0] = 1'b1; rdy_i[0] = 1'b1;
    cyc_end();
    a_i[0] = 1'b0;
    @(negedge clk);
    check("single_valid_c1", 32'(valid_o[0]), 1);
    check("single_pending_c1", 32'(pend_o[0]), 1);
    cyc_end();
    @(negedge clk);
    check("single_valid_c2", 32'(valid_o[0]), 0);
    check("single_pending_c2", 32'(pend_o[0]), 0);
    repeat (3) cyc_end();

    // Burst of three tokens: offers at cycles 1, 4, 7 only.
    for (int i = 0; i < 9; i++) begin
      a_i[0] = (i < 3);
      @(negedge clk);
      vbits[i] = valid_o[0];
      if (i == 8) check("burst_pending_c8", 32'(pend_o[0]), 0);
      cyc_end();
    end
    check("burst_valid_pattern", 32'(vbits), 32'h092);
    repeat (2) cyc_end();

    // Overflow with the sink stalled.
    rdy_i[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_i[0] = (i <= 5);
      @(negedge clk);
      if (i == 4) begin
        check("ovf_pending_c4", 32'(pend_o[0]), 4);
        check("ovf_flag_c4", 32'(ovf_o[0]), 0);
      end
      if (i == 5) check("ovf_flag_c5", 32'(ovf_o[0]), 1);
`ifdef TOKEN_PACER_STATS_EN
      if (i == 6) check("ovf_drop_c6", 32'(drop_o[0]), 2);
`endif
      cyc_end();
    end

    // Take one token, leaving 3 pending with overflow set.
    rdy_i[0] = 1'b1;
    cyc_end();
    rdy_i[0] = 1'b0;
    @(negedge clk);
    check("pre_clr_pending", 32'(pend_o[0]), 3);
    check("pre_clr_overflow", 32'(ovf_o[0]), 1);

    // Clear with a simultaneous token.
    a_i[0] = 1'b1; clr_i[0] = 1'b1;
    cyc_end();
    a_i[0] = 1'b0; clr_i[0] = 1'b0;
    @(negedge clk);
    check("clr_pending", 32'(pend_o[0]), 0);
    check("clr_overflow", 32'(ovf_o[0]), 0);
    check("clr_valid", 32'(valid_o[0]), 0);
`ifdef TOKEN_PACER_STATS_EN
    check("clr_drop", 32'(drop_o[0]), 0);
`endif

    // Full store plus simultaneous token and handshake.
    cyc_end();
    a_i[0] = 1'b1;
    repeat (4) cyc_end();
    rdy_i[0] = 1'b1;
    cyc_end();
    a_i[0] = 1'b0; rdy_i[0] = 1'b0;
    @(negedge clk);
    check("full_simul_pending", 32'(pend_o[0]), 4);
    check("full_simul_overflow", 32'(ovf_o[0]), 0);

    // Reset in the middle of an offer.
    cyc_end();
    clr_i[0] = 1'b1;
    cyc_end();
    clr_i[0] = 1'b0; a_i[0] = 1'b1;
    cyc_end(); cyc_end();
    a_i[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(valid_o[0]), 1);
    check("pre_rst_pending", 32'(pend_o[0]), 2);
    cyc_end();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(valid_o[0]), 0);
    check("rst_mid_pending", 32'(pend_o[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc_end();

    // GAP=0 instance: three queued tokens leave back-to-back.
    rdy_i[1] = 1'b0; a_i[1] = 1'b1;
    repeat (3) cyc_end();
    a_i[1] = 1'b0;
    @(negedge clk);
    check("gap0_queued", 32'(pend_o[1]), 3);
    cyc_end();
    rdy_i[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vb0[i] = valid_o[1];
      if (i == 3) check("gap0_pending_end", 32'(pend_o[1]), 0);
      cyc_end();
    end
    check("gap0_valid_pattern", 32'(vb0), 32'h7);

    repeat (3) cyc_end();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
